// File: rtl/adder_display_sequencer_pkg.sv
// Shared types and constants for the adder display sequencer.
// Holds FSM encodings, digit geometry and seven-segment patterns.
package adder_display_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;

    localparam logic [8:0] VEC_FIRST = 9'h000;
    localparam logic [8:0] VEC_LAST  = 9'h1FF;

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b1000000;
            4'h1:    p = 7'b1111001;
            4'h2:    p = 7'b0100100;
            4'h3:    p = 7'b0110000;
            4'h4:    p = 7'b0011001;
            4'h5:    p = 7'b0010010;
            4'h6:    p = 7'b0000010;
            4'h7:    p = 7'b1111000;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0010000;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b0000011;
            4'hC:    p = 7'b1000110;
            4'hD:    p = 7'b0100001;
            4'hE:    p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/adder_display_sequencer_hex7seg.sv
// Combinational hex-to-seven-segment decoder.
// One instance serves all digits through the nibble mux.
module hex7seg
    import adder_display_sequencer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; patterns are kept in the package
    always_comb begin
        seg = hex_pattern(nibble);
    end

endmodule

// File: rtl/adder_display_sequencer.sv
// 4-bit adder with manual/sweep operand source and a
// multiplexed four-digit seven-segment display.
module adder_display_sequencer
    import adder_display_sequencer_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int STEP_DIV    = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    input  logic       CI,
    input  logic       mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       CO,
    output logic       sweep_done
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST    = SW'(STEP_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [8:0]    vec;
    logic [8:0]    vec_nxt;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] step_cnt_nxt;

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_ci;
    logic [4:0] res_nxt;

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       ci_q;
    logic [4:0] res_q;

    logic [RW-1:0]      refresh_cnt;
    logic [DIGIT_W-1:0] digit_idx;
    logic [3:0]         nibble;
    logic [6:0]         seg_raw;
    logic [3:0]         an_nxt;
    logic               dp_nxt;

    // FSM state, sweep vector and step counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_MANUAL;
            vec      <= VEC_FIRST;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    // Next-state logic: sweep stepping, saturation and mode exits
    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        step_cnt_nxt = step_cnt;
        case (state)
            ST_MANUAL: begin
                vec_nxt      = VEC_FIRST;
                step_cnt_nxt = '0;
                if (mode) begin
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (!mode) begin
                    state_nxt    = ST_MANUAL;
                    step_cnt_nxt = '0;
                end else if (step_cnt == STEP_LAST) begin
                    step_cnt_nxt = '0;
                    if (vec == VEC_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        vec_nxt = vec + 9'd1;
                    end
                end else begin
                    step_cnt_nxt = step_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                step_cnt_nxt = '0;
                if (!mode) begin
                    state_nxt = ST_MANUAL;
                end
            end
            default: begin
                state_nxt    = ST_MANUAL;
                vec_nxt      = VEC_FIRST;
                step_cnt_nxt = '0;
            end
        endcase
    end

    // Operand source: sweep vector outside MANUAL, switches otherwise
    always_comb begin
        op_a  = A1;
        op_b  = B1;
        op_ci = CI;
        if (state != ST_MANUAL) begin
            op_a  = vec[8:5];
            op_b  = vec[4:1];
            op_ci = vec[0];
        end
        res_nxt = {1'b0, op_a} + {1'b0, op_b} + {4'b0000, op_ci};
    end

    // Registered operands and result feed both CO and the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            ci_q  <= 1'b0;
            res_q <= '0;
        end else begin
            a_q   <= op_a;
            b_q   <= op_b;
            ci_q  <= op_ci;
            res_q <= res_nxt;
        end
    end

    assign CO         = res_q[4];
    assign sweep_done = (state == ST_DONE);

    // Refresh divider and digit index; independent of mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            if (digit_idx == DIGIT_LAST) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Digit content mux, anode decode and decimal point
    always_comb begin
        case (digit_idx)
            2'd3:    nibble = a_q;
            2'd2:    nibble = b_q;
            2'd1:    nibble = res_q[3:0];
            default: nibble = {3'b000, res_q[4]};
        endcase
        an_nxt = ~(4'b0001 << digit_idx);
        dp_nxt = !((digit_idx == '0) && ci_q);
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    // Display outputs registered together so an and seg agree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_BLANK;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_raw;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: doc/adder_display_sequencer.md
ADDER_DISPLAY_SEQUENCER -- requirements
Module: adder_display_sequencer

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles each display digit stays active.
REQ-002 Parameter STEP_DIV, default 50000000, SHALL set the number of clk cycles between sweep steps.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 A1  input  4  manual operand A.
REQ-006 B1  input  4  manual operand B.
REQ-007 CI  input  1  manual carry-in.
REQ-008 mode  input  1  SHALL select manual operation at 0 and automatic sweep at 1.
REQ-009 seg  output  7  cathodes {g..a}, active-low.
REQ-010 an  output  4  digit anodes, active-low, one-hot; an[0] is the rightmost digit.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 CO  output  1  carry-out of the currently selected operation, registered.
REQ-013 sweep_done  output  1  SHALL be high while the sweep has covered all 512 combinations.

Function
REQ-014 The FSM SHALL have three states: MANUAL, SWEEP and DONE.
REQ-015 The FSM SHALL move from MANUAL to SWEEP on the first cycle with mode=1, clearing the sweep vector {sA,sB,sCI} to 9'h000.
REQ-016 In SWEEP, the sweep vector SHALL increment by 1 each time the step counter reaches STEP_DIV-1; the step counter SHALL then return to 0.
REQ-017 In SWEEP, when a step occurs with the vector at 9'h1FF, the FSM SHALL enter DONE and the vector SHALL hold at 9'h1FF without wrapping.
REQ-018 The FSM SHALL return to MANUAL from SWEEP or DONE within one cycle of mode=0, and the step counter SHALL clear.
REQ-019 The operand source SHALL be the sweep vector in SWEEP and DONE, and A1/B1/CI in MANUAL.
REQ-020 The 5-bit result {CO,sum} SHALL equal A+B+CI and SHALL be registered, giving one cycle of latency from operand change to CO and display data.
REQ-021 sweep_done SHALL be 1 exactly when the FSM is in DONE.
REQ-022 A 2-bit digit index SHALL advance 0->1->2->3->0 each time the refresh counter reaches REFRESH_DIV-1.
REQ-023 an SHALL be the active-low decode of the digit index.
REQ-024 The display content by digit SHALL be: digit 3 = hex of A, digit 2 = hex of B, digit 1 = hex of sum, digit 0 = CO shown as 0 or 1.
REQ-025 seg SHALL be registered together with an, so the two never disagree within a cycle.
REQ-026 dp SHALL be 0 only while digit 0 is active and the selected CI is 1; otherwise dp SHALL be 1.
REQ-027 A mode change SHALL NOT disturb the refresh counter or the digit index.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state MANUAL, sweep vector 0, step and refresh counters 0, digit index 0, CO 0, sweep_done 0.
REQ-029 While rst_n=0, the display outputs SHALL hold an=4'b1111, seg=7'b1111111 and dp=1 (all blank).
REQ-030 The first active digit after reset release SHALL be digit 0, one cycle after release.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep; after release, a sweep SHALL start again from 9'h000 if mode=1.

Structure
REQ-032 The FSM state encodings, the digit count and the 16 hex segment patterns SHALL live in a shared package/include file.
REQ-033 The hex-to-seven-segment lookup SHALL be a single combinational sub-module, hex7seg, instantiated once on the muxed digit nibble.
REQ-034 The adder SHALL be inferred inside this block, with no further sub-modules.

Verification (REFRESH_DIV=4, STEP_DIV=2)
REQ-035 Reset scenario: rst_n=0 then released -> outputs blank during reset; an=4'b1110 one cycle after release; an rotates 1110->1101->1011->0111 every 4 cycles.
REQ-036 Manual scenario: mode=0, A1=4'hF, B1=4'h1, CI=1 -> CO=1 one cycle later; digit 1 shows seg for "1" (7'b1111001); digit 0 shows "1" with dp=0; digit 3 shows "F".
REQ-037 Full sweep scenario: mode=1 from reset -> vector steps every 2 cycles; sweep_done rises after 512 steps (1024 cycles) with vector 9'h1FF and CO=1; sweep_done stays high.
REQ-038 Mode-drop scenario: mode dropped mid-sweep at vector 9'h0A5 -> MANUAL the next cycle; sweep_done=0; display shows A1/B1; re-raising mode restarts the sweep at 9'h000.
REQ-039 Async reset scenario: rst_n pulsed low for 3 ns between clock edges during SWEEP -> immediate blank and state reset with no clock edge required.
REQ-040 Self-check: a scoreboard SHALL compare {CO,sum} against A+B+CI for every sweep vector, and an SHALL be one-hot-low on every cycle after reset.
